// File: rtl/grf_arb_pkg.sv
// rtl/grf_arb_pkg.sv - shared types and defaults for the GRF write arbiter
package grf_arb_pkg;

    localparam int STARVE_LIM_DEF = 4;
    localparam int FIFO_DEPTH_DEF = 2;
    localparam int QIDX_W         = (FIFO_DEPTH_DEF > 1) ? $clog2(FIFO_DEPTH_DEF) : 1;

    typedef struct packed {
        logic [4:0]  rw;
        logic [31:0] wd;
        logic [31:0] pc;
    } wr_req_t;

endpackage

// File: rtl/grf_arb_fifo.sv
// rtl/grf_arb_fifo.sv - late-write queue with per-register squash and compaction
// Ports: Clk/Reset (async active-low), i_push/i_push_data enqueue at tail,
//        i_pop drops the head, i_sq_en/i_sq_rw invalidate entries by register,
//        o_head head entry, o_full/o_empty status, o_busy_mask registers pending.
module grf_arb_fifo
    import grf_arb_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEF
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        i_push,
    input  wr_req_t     i_push_data,
    input  logic        i_pop,
    input  logic        i_sq_en,
    input  logic [4:0]  i_sq_rw,
    output wr_req_t     o_head,
    output logic        o_full,
    output logic        o_empty,
    output logic [31:0] o_busy_mask
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    wr_req_t          r_ent [DEPTH];
    logic [DEPTH-1:0] r_vld;

    wr_req_t          w_ent_nxt [DEPTH];
    logic [DEPTH-1:0] w_vld_nxt;
    logic [CW-1:0]    w_cnt;

    // Survivors are packed toward index 0 every cycle, so the stored queue is
    // always compacted and entry 0 is the oldest valid write.
    always_comb begin
        w_vld_nxt = '0;
        w_cnt     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_ent_nxt[i] = r_ent[i];
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (r_vld[i] && !(i_pop && (i == 0)) &&
                !(i_sq_en && (r_ent[i].rw == i_sq_rw))) begin
                w_ent_nxt[w_cnt[IW-1:0]] = r_ent[i];
                w_vld_nxt[w_cnt[IW-1:0]] = 1'b1;
                w_cnt = w_cnt + 1'b1;
            end
        end
        if (i_push && (w_cnt < CW'(DEPTH))) begin
            w_ent_nxt[w_cnt[IW-1:0]] = i_push_data;
            w_vld_nxt[w_cnt[IW-1:0]] = 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_vld <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_ent[i] <= '0;
            end
        end else begin
            r_vld <= w_vld_nxt;
            for (int i = 0; i < DEPTH; i++) begin
                r_ent[i] <= w_ent_nxt[i];
            end
        end
    end

    always_comb begin
        o_busy_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_vld[i]) begin
                o_busy_mask[r_ent[i].rw] = 1'b1;
            end
        end
    end

    assign o_head  = r_ent[0];
    assign o_empty = !r_vld[0];
    assign o_full  = &r_vld;

endmodule

// File: rtl/grf_wr_arb.sv
// rtl/grf_wr_arb.sv - GRF write-port arbiter between WB pipeline and late units
// Ports: Clk, Reset (async active-low); p_we/p_rw/p_wd/p_pc pipeline write;
//        l_req/l_rw/l_wd/l_pc late write request, l_ack accept; WE/RW/WD/WPC
//        GRF write port; p_stall registered pipeline hold; busy_mask pending regs.
// Optional: define GRF_ARB_TRACE_EN to print one trace line per GRF write.
module grf_wr_arb
    import grf_arb_pkg::*;
#(
    parameter int STARVE_LIM = STARVE_LIM_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        p_we,
    input  logic [4:0]  p_rw,
    input  logic [31:0] p_wd,
    input  logic [31:0] p_pc,
    input  logic        l_req,
    input  logic [4:0]  l_rw,
    input  logic [31:0] l_wd,
    input  logic [31:0] l_pc,
    output logic        l_ack,
    output logic        WE,
    output logic [4:0]  RW,
    output logic [31:0] WD,
    output logic [31:0] WPC,
    output logic        p_stall,
    output logic [31:0] busy_mask
);

    localparam int AGE_W = $clog2(STARVE_LIM + 1);

    logic [AGE_W-1:0] r_age;
    logic             r_stall;

    wr_req_t          w_head;
    wr_req_t          w_l_ent;
    logic             w_full;
    logic             w_empty;
    logic             w_head_vld;
    logic             w_p_act;
    logic             w_l_act;
    logic             w_pop;
    logic             w_bypass;
    logic             w_l_drop;
    logic             w_space;
    logic             w_push;
    logic             w_head_sq;
    logic             w_held;
    logic [AGE_W-1:0] w_age_nxt;
    logic             w_stall_nxt;

    assign w_l_ent    = '{rw: l_rw, wd: l_wd, pc: l_pc};
    assign w_head_vld = !w_empty;

    // A pipeline write to $0 is a no-op and leaves the port free.
    assign w_p_act  = p_we && (p_rw != 5'd0);
    assign w_l_act  = l_req && (l_rw != 5'd0);
    assign w_pop    = !w_p_act && w_head_vld;
    assign w_bypass = !w_p_act && !w_head_vld && w_l_act;
    // A late write to the register the pipeline is writing right now is
    // already stale (WAW), so it is acknowledged and thrown away.
    assign w_l_drop = w_p_act && w_l_act && (l_rw == p_rw);
    assign w_space  = !w_full || w_pop;
    assign w_push   = w_l_act && !w_bypass && !w_l_drop && w_space;
    assign l_ack    = l_req && (!w_l_act || w_bypass || w_l_drop || w_space);

    grf_arb_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .Clk        (Clk),
        .Reset      (Reset),
        .i_push     (w_push),
        .i_push_data(w_l_ent),
        .i_pop      (w_pop),
        .i_sq_en    (w_p_act),
        .i_sq_rw    (p_rw),
        .o_head     (w_head),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_busy_mask(busy_mask)
    );

    always_comb begin
        WE  = w_p_act || w_pop || w_bypass;
        RW  = l_rw;
        WD  = l_wd;
        WPC = l_pc;
        if (w_p_act) begin
            RW  = p_rw;
            WD  = p_wd;
            WPC = p_pc;
        end else if (w_head_vld) begin
            RW  = w_head.rw;
            WD  = w_head.wd;
            WPC = w_head.pc;
        end
    end

    // Any head change (write, squash, empty queue) restarts the age; the stall
    // rises together with the age reaching STARVE_LIM-1 so the pipeline frees
    // the port on the next cycle.
    assign w_head_sq   = w_p_act && w_head_vld && (w_head.rw == p_rw);
    assign w_held      = w_head_vld && !w_pop && !w_head_sq;
    assign w_age_nxt   = !w_held ? '0 :
                         (r_age == AGE_W'(STARVE_LIM)) ? r_age : r_age + 1'b1;
    assign w_stall_nxt = w_held && (w_age_nxt >= AGE_W'(STARVE_LIM - 1));

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_age   <= '0;
            r_stall <= 1'b0;
        end else begin
            r_age   <= w_age_nxt;
            r_stall <= w_stall_nxt;
        end
    end

    assign p_stall = r_stall;

`ifdef GRF_ARB_TRACE_EN
    always @(posedge Clk) begin
        if (Reset && WE) begin
            $display("%0t@%h: $%0d <= %h", $time, WPC, RW, WD);
        end
    end
`endif

endmodule

// File: tb/tb_grf_wr_arb.sv
// tb/tb_grf_wr_arb.sv - directed self-checking bench for grf_wr_arb
module tb_grf_wr_arb;

    logic        Clk;
    logic        Reset;
    logic        p_we;
    logic [4:0]  p_rw;
    logic [31:0] p_wd;
    logic [31:0] p_pc;
    logic        l_req;
    logic [4:0]  l_rw;
    logic [31:0] l_wd;
    logic [31:0] l_pc;
    logic        l_ack;
    logic        WE;
    logic [4:0]  RW;
    logic [31:0] WD;
    logic [31:0] WPC;
    logic        p_stall;
    logic [31:0] busy_mask;

    int total;
    int bad;

    grf_wr_arb dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .p_we     (p_we),
        .p_rw     (p_rw),
        .p_wd     (p_wd),
        .p_pc     (p_pc),
        .l_req    (l_req),
        .l_rw     (l_rw),
        .l_wd     (l_wd),
        .l_pc     (l_pc),
        .l_ack    (l_ack),
        .WE       (WE),
        .RW       (RW),
        .WD       (WD),
        .WPC      (WPC),
        .p_stall  (p_stall),
        .busy_mask(busy_mask)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic drive_p(input logic we, input logic [4:0] rw, input logic [31:0] wd, input logic [31:0] pc);
        p_we = we; p_rw = rw; p_wd = wd; p_pc = pc;
    endtask

    task automatic drive_l(input logic req, input logic [4:0] rw, input logic [31:0] wd, input logic [31:0] pc);
        l_req = req; l_rw = rw; l_wd = wd; l_pc = pc;
    endtask

    task automatic test_reset;
        Reset = 1'b0;
        drive_p(0, 0, 0, 0);
        drive_l(0, 0, 0, 0);
        repeat (2) @(negedge Clk);
        #1;
        total++; if (WE !== 1'b0) begin bad++; $display("FAIL reset_we act=%0h exp=0", WE); end
        total++; if (busy_mask !== 32'h0) begin bad++; $display("FAIL reset_busy act=%h exp=0", busy_mask); end
        total++; if (p_stall !== 1'b0) begin bad++; $display("FAIL reset_stall act=%0h exp=0", p_stall); end
        total++; if (l_ack !== 1'b0) begin bad++; $display("FAIL reset_ack act=%0h exp=0", l_ack); end
        @(negedge Clk);
        Reset = 1'b1;
    endtask

    task automatic test_bypass;
        @(negedge Clk);
        drive_l(1, 5'd5, 32'h1234, 32'h3000);
        #1;
        total++; if (WE !== 1'b1) begin bad++; $display("FAIL byp_we act=%0h exp=1", WE); end
        total++; if (RW !== 5'd5) begin bad++; $display("FAIL byp_rw act=%0d exp=5", RW); end
        total++; if (WD !== 32'h1234) begin bad++; $display("FAIL byp_wd act=%h exp=1234", WD); end
        total++; if (WPC !== 32'h3000) begin bad++; $display("FAIL byp_pc act=%h exp=3000", WPC); end
        total++; if (l_ack !== 1'b1) begin bad++; $display("FAIL byp_ack act=%0h exp=1", l_ack); end
        total++; if (busy_mask !== 32'h0) begin bad++; $display("FAIL byp_busy act=%h exp=0", busy_mask); end
        @(negedge Clk);
        drive_l(0, 0, 0, 0);
        #1;
        total++; if (WE !== 1'b0) begin bad++; $display("FAIL byp_after_we act=%0h exp=0", WE); end
        total++; if (busy_mask !== 32'h0) begin bad++; $display("FAIL byp_after_busy act=%h exp=0", busy_mask); end
    endtask

    task automatic test_starve;
        logic exp_stall;
        for (int c = 0; c < 8; c++) begin
            @(negedge Clk);
            if (c < 6) drive_p(1, 5'd3, 32'h30 + c, 32'h100 + c);
            else       drive_p(0, 0, 0, 0);
            if (c == 0) drive_l(1, 5'd7, 32'h77, 32'h700);
            else        drive_l(0, 0, 0, 0);
            #1;
            exp_stall = (c >= 4) && (c <= 6);
            total++; if (p_stall !== exp_stall) begin bad++; $display("FAIL starve_stall c=%0d act=%0h exp=%0h", c, p_stall, exp_stall); end
            if (c == 0) begin
                total++; if (l_ack !== 1'b1) begin bad++; $display("FAIL starve_ack act=%0h exp=1", l_ack); end
            end
            if (c < 6) begin
                total++; if (WE !== 1'b1 || RW !== 5'd3) begin bad++; $display("FAIL starve_pwin c=%0d act=%0h/%0d exp=1/3", c, WE, RW); end
            end
            if (c >= 1 && c <= 6) begin
                total++; if (busy_mask !== 32'h80) begin bad++; $display("FAIL starve_busy c=%0d act=%h exp=80", c, busy_mask); end
            end
            if (c == 6) begin
                total++; if (WE !== 1'b1 || RW !== 5'd7 || WD !== 32'h77) begin bad++; $display("FAIL starve_drain act=%0h/%0d/%h exp=1/7/77", WE, RW, WD); end
            end
            if (c == 7) begin
                total++; if (WE !== 1'b0 || busy_mask !== 32'h0) begin bad++; $display("FAIL starve_end act=%0h/%h exp=0/0", WE, busy_mask); end
            end
        end
    endtask

    task automatic test_full;
        @(negedge Clk);
        drive_p(1, 5'd3, 32'h3, 32'h0);
        drive_l(1, 5'd9, 32'h9, 32'h900);
        #1;
        total++; if (l_ack !== 1'b1) begin bad++; $display("FAIL full_ack9 act=%0h exp=1", l_ack); end
        @(negedge Clk);
        drive_l(1, 5'd10, 32'h10, 32'hA00);
        #1;
        total++; if (l_ack !== 1'b1) begin bad++; $display("FAIL full_ack10 act=%0h exp=1", l_ack); end
        for (int c = 0; c < 2; c++) begin
            @(negedge Clk);
            drive_l(1, 5'd11, 32'hB1, 32'hB00);
            #1;
            total++; if (l_ack !== 1'b0) begin bad++; $display("FAIL full_noack c=%0d act=%0h exp=0", c, l_ack); end
            total++; if (busy_mask !== 32'h600) begin bad++; $display("FAIL full_busy c=%0d act=%h exp=600", c, busy_mask); end
        end
        @(negedge Clk);
        drive_p(0, 0, 0, 0);
        #1;
        total++; if (l_ack !== 1'b1) begin bad++; $display("FAIL full_popack act=%0h exp=1", l_ack); end
        total++; if (WE !== 1'b1 || RW !== 5'd9 || WD !== 32'h9) begin bad++; $display("FAIL full_w9 act=%0h/%0d/%h exp=1/9/9", WE, RW, WD); end
        @(negedge Clk);
        drive_l(0, 0, 0, 0);
        #1;
        total++; if (WE !== 1'b1 || RW !== 5'd10 || WD !== 32'h10) begin bad++; $display("FAIL full_w10 act=%0h/%0d/%h exp=1/10/10", WE, RW, WD); end
        @(negedge Clk);
        #1;
        total++; if (WE !== 1'b1 || RW !== 5'd11 || WD !== 32'hB1) begin bad++; $display("FAIL full_w11 act=%0h/%0d/%h exp=1/11/b1", WE, RW, WD); end
        @(negedge Clk);
        #1;
        total++; if (WE !== 1'b0 || busy_mask !== 32'h0) begin bad++; $display("FAIL full_end act=%0h/%h exp=0/0", WE, busy_mask); end
    endtask

    task automatic test_squash;
        @(negedge Clk);
        drive_p(1, 5'd3, 32'h3, 32'h0);
        drive_l(1, 5'd9, 32'hA, 32'h900);
        @(negedge Clk);
        drive_p(1, 5'd9, 32'hB, 32'h904);
        drive_l(0, 0, 0, 0);
        #1;
        total++; if (busy_mask !== 32'h200) begin bad++; $display("FAIL sq_busy_pre act=%h exp=200", busy_mask); end
        total++; if (WE !== 1'b1 || RW !== 5'd9 || WD !== 32'hB) begin bad++; $display("FAIL sq_pwrite act=%0h/%0d/%h exp=1/9/b", WE, RW, WD); end
        @(negedge Clk);
        drive_p(0, 0, 0, 0);
        #1;
        total++; if (busy_mask !== 32'h0) begin bad++; $display("FAIL sq_busy_post act=%h exp=0", busy_mask); end
        total++; if (WE !== 1'b0) begin bad++; $display("FAIL sq_nostale act=%0h exp=0", WE); end
        @(negedge Clk);
        drive_p(1, 5'd12, 32'hC, 32'hC00);
        drive_l(1, 5'd12, 32'hD, 32'hD00);
        #1;
        total++; if (l_ack !== 1'b1 || WD !== 32'hC) begin bad++; $display("FAIL sq_ldrop act=%0h/%h exp=1/c", l_ack, WD); end
        @(negedge Clk);
        drive_p(0, 0, 0, 0);
        drive_l(0, 0, 0, 0);
        #1;
        total++; if (WE !== 1'b0 || busy_mask !== 32'h0) begin bad++; $display("FAIL sq_ldrop_end act=%0h/%h exp=0/0", WE, busy_mask); end
    endtask

    task automatic test_zero;
        @(negedge Clk);
        drive_p(1, 5'd0, 32'hDEAD, 32'h0);
        drive_l(1, 5'd0, 32'hBEEF, 32'h0);
        #1;
        total++; if (l_ack !== 1'b1) begin bad++; $display("FAIL zero_ack act=%0h exp=1", l_ack); end
        total++; if (WE !== 1'b0) begin bad++; $display("FAIL zero_we act=%0h exp=0", WE); end
        @(negedge Clk);
        drive_p(0, 0, 0, 0);
        drive_l(0, 0, 0, 0);
        #1;
        total++; if (WE !== 1'b0 || busy_mask !== 32'h0) begin bad++; $display("FAIL zero_end act=%0h/%h exp=0/0", WE, busy_mask); end
    endtask

    task automatic test_reset_mid;
        for (int c = 0; c < 5; c++) begin
            @(negedge Clk);
            drive_p(1, 5'd3, 32'h3, 32'h0);
            if (c == 0)      drive_l(1, 5'd20, 32'h20, 32'h0);
            else if (c == 1) drive_l(1, 5'd21, 32'h21, 32'h0);
            else             drive_l(0, 0, 0, 0);
        end
        #1;
        total++; if (busy_mask !== 32'h0030_0000) begin bad++; $display("FAIL rst_busy_pre act=%h exp=300000", busy_mask); end
        total++; if (p_stall !== 1'b1) begin bad++; $display("FAIL rst_stall_pre act=%0h exp=1", p_stall); end
        #1;
        drive_p(0, 0, 0, 0);
        Reset = 1'b0;
        #1;
        total++; if (busy_mask !== 32'h0) begin bad++; $display("FAIL rst_busy act=%h exp=0", busy_mask); end
        total++; if (p_stall !== 1'b0) begin bad++; $display("FAIL rst_stall act=%0h exp=0", p_stall); end
        total++; if (WE !== 1'b0) begin bad++; $display("FAIL rst_we act=%0h exp=0", WE); end
        @(negedge Clk);
        Reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge Clk);
            #1;
            total++; if (WE !== 1'b0) begin bad++; $display("FAIL rst_stale c=%0d act=%0h exp=0", c, WE); end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset;
        test_bypass;
        test_starve;
        test_full;
        test_squash;
        test_zero;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/grf_wr_arb.md
GRF_WR_ARB -- requirements
Module: grf_wr_arb

Interface
REQ-001 Parameter STARVE_LIM, default 4: cycles a queued late write may wait before the pipeline is stalled.
REQ-002 Parameter FIFO_DEPTH, default 2, fixed: late-write queue depth.
REQ-003 Clk  in  1  single clock; all state updates on posedge Clk.
REQ-004 Reset  in  1  asynchronous, active-low reset (asserted when 0).
REQ-005 p_we, p_rw[4:0], p_wd[31:0], p_pc[31:0]  in  pipeline WB write; never back-pressured.
REQ-006 l_req, l_rw[4:0], l_wd[31:0], l_pc[31:0]  in  late-unit (MDU/load) write request.
REQ-007 l_ack  out  1  late request accepted this cycle.
REQ-008 WE, RW[4:0], WD[31:0], WPC[31:0]  out  GRF write port, combinational.
REQ-009 p_stall  out  1  registered; pipeline holds WB, and drives p_we=0, next cycle.
REQ-010 busy_mask[31:0]  out  bit r set iff a valid queued entry targets register r.

Function
REQ-011 Priority: p_we with p_rw!=0 always wins the GRF port; WE=1, RW/WD/WPC = p_rw/p_wd/p_pc.
REQ-012 p_we with p_rw==0 is treated as idle; WE stays 0 for it.
REQ-013 Port idle and queue non-empty: queue head written (WE=1) and popped the same cycle.
REQ-014 Port idle, queue empty, l_req, l_rw!=0: bypass; late write issued directly, l_ack=1, nothing enqueued.
REQ-015 l_ack = l_req and (bypass taken or queue not full after this cycle's pop); accepted non-bypass requests enqueue at the tail.
REQ-016 l_req with l_rw==0: l_ack=1, request discarded, no enqueue, no write.
REQ-017 Queue full, no pop this cycle: l_ack=0; requester holds l_req and payload stable until acked.
REQ-018 Simultaneous pop and push on a full queue: push accepted.
REQ-019 WAW squash: P write to register r (r!=0) invalidates every queued entry with rw==r the same cycle; a same-cycle L request to r is acked and dropped.
REQ-020 Squashed entries never reach WE; queue compacts so the oldest valid entry is the head next cycle.
REQ-021 Head age counter: cleared on head change; +1 per cycle the head is valid and not written; saturates at STARVE_LIM.
REQ-022 p_stall set at posedge when age == STARVE_LIM-1 and head not written this cycle; cleared the cycle after the head is written or squashed.
REQ-023 During p_stall=1, an illegal p_we=1 still wins per REQ-011; stall persists.
REQ-024 busy_mask combinational from queue valid/rw; bypassed writes never set it.
REQ-025 Writes leave in program-arrival order among late requests; at most one GRF write per cycle.

Reset
REQ-026 Reset=0 asynchronously: queue empty, ages 0, p_stall=0; hence WE=0, busy_mask=0, l_ack follows bypass rule only.
REQ-027 Reset mid-operation drops queued writes without issuing them; no partial write occurs.

Configuration
REQ-028 GRF_ARB_TRACE_EN defined: each cycle with WE=1 prints "<time>@<WPC hex>: $<RW> <= <WD hex>"; undefined: no display code, identical logic.

Structure
REQ-029 Package grf_arb_pkg holds wr_req_t {rw[4:0], wd[31:0], pc[31:0]}, STARVE_LIM/FIFO_DEPTH defaults, queue-index width.
REQ-030 Sub-module grf_arb_fifo: FIFO_DEPTH entries with per-entry valid, squash-by-register input, compaction, head/full/empty outputs.
REQ-031 grf_wr_arb contains port mux, bypass/ack logic, age counter, stall register.

Verification
REQ-032 Port idle, l_req rw=5 wd=0x1234 pc=0x3000 -> same cycle WE=1 RW=5 WD=0x1234 l_ack=1, busy_mask=0.
REQ-033 p_we rw=3 for 6 cycles, l_req rw=7 at cycle 0 -> ack, busy_mask[7]=1, p_stall=1 at cycle 4, idle cycle writes rw=7, p_stall=0 next.
REQ-034 Queue holds rw=9 and rw=10, third l_req while p_we busy -> l_ack=0 until a pop; then accepted, order 9,10,third.
REQ-035 Queue holds rw=9 wd=0xA; p_we rw=9 wd=0xB -> WD=0xB, entry squashed, busy_mask[9]=0, no later write of 0xA.
REQ-036 l_req rw=0 and p_we rw=0 -> l_ack=1, WE=0, queue unchanged.
REQ-037 Two queued entries, Reset=0 mid-cycle -> immediately busy_mask=0, p_stall=0, WE=0; after release no stale write.
